// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and baud divider helper.
// Used by both the receive and transmit ends of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HI
  } state_t;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  function automatic int tick_div(
    input int clk_freq,
    input int baud_rate,
    input int oversample
  );
    return clk_freq / (baud_rate * oversample);
  endfunction

  // Maps the textual PARITY parameter onto a mode code.
  function automatic parity_t parity_mode(input logic [31:0] s);
    if (s == 32'("even")) return PAR_EVEN;
    if (s == 32'("odd")) return PAR_ODD;
    return PAR_NONE;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running tick generator: one-cycle pulse every tick_div clocks.
// Serves as the oversample clock enable for the UART FSMs.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_glb,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_glb) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == TOP) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TOP);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detect, mid-bit sampling,
// single-entry valid/ready output register with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WORD_LENGTH = 8,
  parameter     PARITY      = "none",
  parameter int STOP_BITS   = 1,
  parameter int BAUD_RATE   = 9600,
  parameter int CLK_FREQ    = 50_000_000,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                   clk_glb,
  input  logic                   rst_n,
  input  logic                   rx_in,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   rx_busy
);

  localparam parity_t PMODE = parity_mode(PARITY);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WORD_LENGTH + 1);
  localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] WLAST = BW'(WORD_LENGTH - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);

  logic                   tick;
  logic [1:0]             sync;
  logic                   rx_s;
  state_t                 state;
  logic [SW-1:0]          scnt;
  logic [BW-1:0]          bcnt;
  logic [WORD_LENGTH-1:0] shreg;
  logic                   perr;
  logic                   ferr;
  logic                   ferr_n;
  logic                   exp_par;
  logic                   dlv;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud (
    .clk_glb(clk_glb),
    .rst_n  (rst_n),
    .tick   (tick)
  );

  always_ff @(posedge clk_glb) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_in};
    end
  end

  assign rx_s    = sync[1];
  assign exp_par = (PMODE == PAR_ODD) ? ~^shreg : ^shreg;
  assign ferr_n  = ferr | ~rx_s;
  assign rx_busy = (state != IDLE);

  // scnt is re-zeroed at mid start bit, so every LAST lands mid-bit.
  always_ff @(posedge clk_glb) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt  <= '0;
      bcnt  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      dlv   <= 1'b0;
    end else begin
      dlv <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              scnt  <= '0;
              state <= START;
            end
          end
          START: begin
            if (scnt == MID) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                scnt  <= '0;
                bcnt  <= '0;
                perr  <= 1'b0;
                ferr  <= 1'b0;
                state <= DATA;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          DATA: begin
            if (scnt == LAST) begin
              scnt  <= '0;
              shreg <= {rx_s, shreg[WORD_LENGTH-1:1]};
              if (bcnt == WLAST) begin
                bcnt  <= '0;
                state <= (PMODE == PAR_NONE) ? STOP : PAR;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          PAR: begin
            if (scnt == LAST) begin
              scnt  <= '0;
              perr  <= (rx_s != exp_par);
              state <= STOP;
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          STOP: begin
            if (scnt == LAST) begin
              scnt <= '0;
              ferr <= ferr_n;
              if (bcnt == SLAST) begin
                bcnt  <= '0;
                dlv   <= 1'b1;
                state <= ferr_n ? WAIT_HI : IDLE;
              end else begin
                bcnt <= bcnt + 1'b1;
              end
            end else begin
              scnt <= scnt + 1'b1;
            end
          end
          WAIT_HI: begin
            if (rx_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_glb) begin
    if (!rst_n) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (dlv) begin
      rx_data     <= shreg;
      parity_err  <= perr;
      frame_err   <= ferr;
      overrun_err <= rx_valid && !rx_ready;
      rx_valid    <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver: the receive end of the line driven by `uart_tx`. It synchronises the asynchronous `rx_in` line, detects start bits by 16x oversampling, and samples each data, parity and stop bit at mid-bit. Each received word, with its error flags, is presented on a single-entry valid/ready output register. It sits between the board pin and the consumer logic, with the same frame format and parameter set as `uart_tx`.

## Interface
- `WORD_LENGTH`, 8, data bits per frame, LSB first.
- `PARITY`, "none", one of "none", "even" or "odd".
- `STOP_BITS`, 1, stop bits expected (1 or 2).
- `BAUD_RATE`, 9600, line bit rate in Hz.
- `CLK_FREQ`, 50_000_000, `clk_glb` frequency in Hz.
- `OVERSAMPLE`, 16, sample ticks per bit period. Must be even and ≥8.

Ports:
- `clk_glb`  in  1  sole clock.
- `rst_n`  in  1  reset, **synchronous, active-low**.
- `rx_in`  in  1  asynchronous serial line; idle level is high.
- `rx_data`  out  WORD_LENGTH  last received word.
- `rx_valid`  out  1  `rx_data` and the error flags are valid.
- `rx_ready`  in  1  consumer accepts the word on any edge where `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch on the word in `rx_data`.
- `frame_err`  out  1  a stop bit sampled low on the word in `rx_data`.
- `overrun_err`  out  1  the previous unaccepted word was overwritten.
- `rx_busy`  out  1  high whenever the state is not IDLE.

## Operation
- `rx_in` passes through a 2-flop synchroniser to give `rx_s`, adding 2 cycles of latency. Only `rx_s` is used internally.
- A free-running tick generator pulses `tick` once every `TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE)` cycles. Its counter runs 0..TICK_DIV-1 and wraps to 0.
- All state-machine work happens on `tick` cycles. The sample counter `scnt` runs 0..OVERSAMPLE-1.
- IDLE: if `rx_s==0` on a tick, clear `scnt` and go to START.
- START: at `scnt==OVERSAMPLE/2-1` (mid start bit), check the line:
  - if `rx_s==1`, treat it as a glitch and return to IDLE with no output;
  - otherwise clear `scnt`, clear the bit counter and go to DATA.
- DATA: at each `scnt==OVERSAMPLE-1`, shift `rx_s` into the MSB of the shift register (LSB-first reception).
  - After WORD_LENGTH bits, go to PAR if `PARITY != "none"`, else go to STOP.
- PAR: at mid-bit, capture `rx_s` and compute the expected parity:
  - "even": expected = `^data`;
  - "odd": expected = `~^data`;
  - `perr = (sample != expected)`.
- STOP: at each mid-stop sample, set `ferr` if `rx_s==0`. At the mid-sample of the last stop bit, deliver the word (below) and leave STOP:
  - if `ferr==0`, go to IDLE;
  - if `ferr==1`, go to WAIT_HI.
- WAIT_HI: stay until `rx_s==1` on a tick, then go to IDLE. This stops a break (line held low) from retriggering reception.
- Deliver: on the following clock, load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid=1`.
  - If `rx_valid` was already 1 and is not being accepted on that same edge, also set `overrun_err=1`; otherwise clear `overrun_err`.
- Accept: `rx_valid && rx_ready` clears `rx_valid` on the next edge. The data and flags hold their values until the next delivery.
- Simultaneous accept and deliver on one edge: the new word is loaded, `rx_valid` stays 1 and `overrun_err=0`.
- Errors never suppress delivery. The word is always delivered with its flags.

## Timing
- Reset: on an edge with `rst_n==0`:
  - `rx_data=0`, `rx_valid=0`, all error flags 0, `rx_busy=0`;
  - state IDLE, all counters 0, synchroniser flops set to 1.
- Reset mid-frame aborts the frame with no delivery.
- Start detection has a resolution of 1 tick. Sampling lands within ±1 tick of true mid-bit.
- Latency from the last stop-bit mid-sample to `rx_valid` rising: 1 `clk_glb` cycle.
- The receiver re-arms at the last stop-bit mid-sample, so back-to-back frames with no idle gap are received.
- `rx_ready` may be held high permanently. `rx_valid` is then high for exactly 1 cycle per word.

## Structure
- Shared package `uart_pkg`, also used by `uart_tx`:
  - state encoding (IDLE, START, DATA, PAR, STOP, WAIT_HI);
  - parity-mode constants;
  - a `tick_div` constant function.
- Sub-module `uart_baud_gen`: parameters CLK_FREQ, BAUD_RATE and OVERSAMPLE; output `tick`. It is reused by `uart_tx` with OVERSAMPLE=1.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000, OVERSAMPLE=16, giving TICK_DIV=10 and 160 clocks per bit.
- 8N1 frame 0xA5 → `rx_data=0xA5` with all errors 0. `rx_valid` rises about 1522 cycles after the start edge and clears 1 cycle after `rx_ready`.
- Low glitch of 40 clocks on an idle line → `rx_valid` never asserts, and `rx_busy` returns to 0 within 90 clocks.
- PARITY="even", frame 0x07 with parity bit 0 → `rx_data=0x07`, `parity_err=1`. The same frame with parity bit 1 gives `parity_err=0`.
- Break: line held low for 20 bit times, then high → one word 0x00 with `frame_err=1`. No second word, and the next frame 0x5A is received cleanly.
- Back-to-back frames 0x11 then 0x22 with `rx_ready=0` → `rx_data=0x22`, `overrun_err=1`. Raising `rx_ready` then clears `rx_valid` on the next edge.
- `rst_n` low for 1 cycle during data bit 3 → all outputs 0 on the next edge and no word from that frame. The following frame 0x3C is received correctly.
